// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first ripple adder with start/done handshake
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    // Counter only needs to reach WIDTH-1; it is held on the final edge so it never wraps.
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum;
    logic             fa_cout;

    // Single full-adder cell working on the current LSBs and the registered carry.
    always_comb begin
        fa_sum  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_cout = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    end

    // Next-state and datapath; results are published only on the final ADD edge.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        count_d  = count_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d   = A;
                    b_sr_d   = B;
                    carry_d  = Cin;
                    sum_sr_d = '0;
                    count_d  = '0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_cout;
                if (count_q == LAST) begin
                    // carry_q here is the carry into the MSB, so XOR with carry-out flags signed overflow.
                    sum_d   = {fa_sum, sum_sr_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = fa_cout ^ carry_q;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign Sum   = sum_q;
    assign Cout  = cout_q;
    assign Ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH 8 and 4
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst8 = 1'b0;
    logic       rst4 = 1'b0;
    logic       s8 = 1'b0, c8 = 1'b0, s4 = 1'b0, c4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] a4 = '0, b4 = '0;

    logic       ready8, busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       ready4, busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(s8), .A(a8), .B(b8), .Cin(c8),
        .ready(ready8), .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8), .Ovf(ovf8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(s4), .A(a4), .B(b4), .Cin(c4),
        .ready(ready4), .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4), .Ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Arithmetic reference: unsigned sum modulo 2^w, carry-out as bit w, overflow from signed range.
    function automatic void calc(input int w, input longint a, input longint b, input bit cin,
                                 output logic [31:0] s, output bit co, output bit ov);
        longint full, half, sa, sb, ss;
        full = a + b + longint'(cin);
        s    = 32'(full & ((longint'(1) << w) - 1));
        co   = ((full >> w) & 1) != 0;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        ss   = sa + sb + longint'(cin);
        ov   = (ss > half - 1) || (ss < -half);
    endfunction

    // Transaction-level model: accept in idle, result and done appear w edges later, idle again one edge after.
    logic [31:0] m_sum[2], p_sum[2];
    bit          m_cout[2], m_ovf[2], p_cout[2], p_ovf[2], m_idle[2], m_done[2];
    int          m_t[2];

    task automatic mreset(input int i);
        m_idle[i] = 1'b1;
        m_done[i] = 1'b0;
        m_sum[i]  = '0;
        m_cout[i] = 1'b0;
        m_ovf[i]  = 1'b0;
        m_t[i]    = 0;
    endtask

    task automatic mstep(input int i, input bit st, input logic [31:0] a, input logic [31:0] b,
                         input bit cin, input int w);
        logic [31:0] s;
        bit co, ov;
        if (m_idle[i]) begin
            if (st) begin
                calc(w, longint'(a), longint'(b), cin, s, co, ov);
                p_sum[i]  = s;
                p_cout[i] = co;
                p_ovf[i]  = ov;
                m_idle[i] = 1'b0;
                m_t[i]    = 0;
            end
        end else begin
            m_t[i]++;
            if (m_t[i] == w) begin
                m_sum[i]  = p_sum[i];
                m_cout[i] = p_cout[i];
                m_ovf[i]  = p_ovf[i];
                m_done[i] = 1'b1;
            end else if (m_t[i] == w + 1) begin
                m_done[i] = 1'b0;
                m_idle[i] = 1'b1;
            end
        end
    endtask

    initial begin
        mreset(0);
        mreset(1);
    end

    always @(posedge clk or posedge rst8)
        if (rst8) mreset(0);
        else mstep(0, s8, 32'(a8), 32'(b8), c8, 8);

    always @(posedge clk or posedge rst4)
        if (rst4) mreset(1);
        else mstep(1, s4, 32'(a4), 32'(b4), c4, 4);

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready8", 32'(ready8), 32'(m_idle[0]));
            check("busy8",  32'(busy8),  32'(!m_idle[0]));
            check("done8",  32'(done8),  32'(m_done[0]));
            check("sum8",   32'(sum8),   m_sum[0]);
            check("cout8",  32'(cout8),  32'(m_cout[0]));
            check("ovf8",   32'(ovf8),   32'(m_ovf[0]));
            check("ready4", 32'(ready4), 32'(m_idle[1]));
            check("busy4",  32'(busy4),  32'(!m_idle[1]));
            check("done4",  32'(done4),  32'(m_done[1]));
            check("sum4",   32'(sum4),   m_sum[1]);
            check("cout4",  32'(cout4),  32'(m_cout[1]));
            check("ovf4",   32'(ovf4),   32'(m_ovf[1]));
        end
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] s, output logic co, output logic ov,
                       output int lat, output int busy_n);
        @(negedge clk);
        a8 = a; b8 = b; c8 = cin; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        lat = -1; busy_n = 0; s = '0; co = 1'b0; ov = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (busy8) busy_n++;
            if (done8 && lat < 0) begin
                lat = k; s = sum8; co = cout8; ov = ovf8;
            end
            @(negedge clk);
        end
    endtask

    task automatic dir8();
        logic [7:0] s;
        logic co, ov;
        int lat, bn, dn, dsum, first, last_d, gap_bad;

        op8(8'h5A, 8'h33, 1'b0, s, co, ov, lat, bn);
        check("t1_latency", 32'(lat), 32'd8);
        check("t1_busy_cycles", 32'(bn), 32'd9);
        check("t1_sum", 32'(s), 32'h8D);
        check("t1_cout", 32'(co), 32'd0);
        check("t1_ovf", 32'(ov), 32'd1);

        op8(8'hFF, 8'h01, 1'b0, s, co, ov, lat, bn);
        check("t2a_sum", 32'(s), 32'h00);
        check("t2a_cout", 32'(co), 32'd1);
        check("t2a_ovf", 32'(ov), 32'd0);

        op8(8'h7F, 8'h00, 1'b1, s, co, ov, lat, bn);
        check("t2b_sum", 32'(s), 32'h80);
        check("t2b_cout", 32'(co), 32'd0);
        check("t2b_ovf", 32'(ov), 32'd1);

        // start and new operands during ADD must be ignored
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF;
        dn = 0; dsum = 0;
        for (int k = 0; k < 20; k++) begin
            if (done8) begin
                dn++; dsum = int'(sum8);
            end
            if (k == 8) s8 = 1'b0;
            @(negedge clk);
        end
        check("t3_done_count", 32'(dn), 32'd1);
        check("t3_sum", 32'(dsum), 32'h30);

        // reset in the middle of an operation
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h06; s8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t4_hold_sum", 32'(sum8), 32'h30);
        rst8 = 1'b1;
        #1;
        check("t4_rst_sum", 32'(sum8), 32'h0);
        check("t4_rst_cout", 32'(cout8), 32'd0);
        check("t4_rst_ovf", 32'(ovf8), 32'd0);
        check("t4_rst_done", 32'(done8), 32'd0);
        check("t4_rst_ready", 32'(ready8), 32'd1);
        check("t4_rst_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        op8(8'h01, 8'h02, 1'b0, s, co, ov, lat, bn);
        check("t4_after_sum", 32'(s), 32'h03);

        // continuous start: back-to-back every WIDTH+2 cycles
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; c8 = 1'b1; s8 = 1'b1;
        dn = 0; first = -1; last_d = -1; gap_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done8) begin
                if (first < 0) first = k;
                if (last_d >= 0 && k - last_d != 10) gap_bad++;
                last_d = k;
                dn++;
            end
            a8 = 8'(k * 37 + 5);
            b8 = 8'(k * 91 + 3);
            c8 = k[0];
        end
        s8 = 1'b0;
        check("t5_done_count", 32'(dn), 32'd4);
        check("t5_first_done", 32'(first), 32'd8);
        check("t5_gap_errors", 32'(gap_bad), 32'd0);
        repeat (12) @(negedge clk);
    endtask

    task automatic sweep4();
        int ops, n;
        ops = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    a4 = 4'(a); b4 = 4'(b); c4 = c[0]; s4 = 1'b1;
                    @(negedge clk);
                    s4 = 1'b0;
                    n = 0;
                    while (!done4 && n < 10) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!done4) begin
                        check("sweep_done_timeout", 32'd0, 32'd1);
                    end else begin
                        ops++;
                        check("sweep_sum", 32'({cout4, sum4}), 32'(a + b + c));
                    end
                    @(negedge clk);
                end
            end
        end
        check("sweep_ops", 32'(ops), 32'd512);
    endtask

    initial begin
        #1;
        rst8 = 1'b1;
        rst4 = 1'b1;
        #1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready8), 32'd1);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'({cout8, ovf8, sum8}), 32'd0);
        rst8 = 1'b0;
        rst4 = 1'b0;
        fork
            dir8();
            sweep4();
        join
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
